// File: rtl/pipe_hazard_ctrl.sv
// Hazard and stall controller for the 5-stage pipeline: load-use stalls, MEM-stage
// branch flushes, multi-cycle data-memory waits, plus saturating stall/flush counters.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   S_RUN  | normal flow; a new memory access starts a wait here
//   S_WAIT | memory still busy; rem counts the remaining extra wait cycles
//   S_DONE | access completes; advancing cycle, mem_access_i ignored
module pipe_hazard_ctrl #(
   parameter int MEM_LAT = 2,
   parameter int CNT_W   = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [4:0]       id_rs_i,
   input  logic [4:0]       id_rt_i,
   input  logic             id_uses_rt_i,
   input  logic             ex_memread_i,
   input  logic [4:0]       ex_rt_i,
   input  logic             mem_branch_taken_i,
   input  logic             mem_access_i,
   output logic             pc_write_o,
   output logic             ifid_write_o,
   output logic             ifid_flush_o,
   output logic             idex_flush_o,
   output logic             exmem_flush_o,
   output logic             mem_wait_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o
);

   typedef enum logic [1:0] {S_RUN, S_WAIT, S_DONE} state_t;

   localparam logic [3:0] REM_INIT = (MEM_LAT >= 3) ? 4'(MEM_LAT - 3) : 4'd0;

   state_t           state_q, state_d;
   logic [3:0]       rem_q, rem_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
   logic             mem_wait;
   logic             load_use;
   logic             br_flush;

   always_comb begin
      state_d  = state_q;
      rem_d    = rem_q;
      mem_wait = 1'b0;
      case (state_q)
         S_RUN: begin
            if (mem_access_i && (MEM_LAT > 1)) begin
               mem_wait = 1'b1;
               if (MEM_LAT == 2) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_WAIT;
                  rem_d   = REM_INIT;
               end
            end
         end
         S_WAIT: begin
            mem_wait = 1'b1;
            if (rem_q == 4'd0) state_d = S_DONE;
            else               rem_d   = rem_q - 4'd1;
         end
         S_DONE:  state_d = S_RUN;
         default: state_d = S_RUN;
      endcase
   end

   assign load_use = ex_memread_i && (ex_rt_i != 5'd0) &&
                     ((ex_rt_i == id_rs_i) || (id_uses_rt_i && (ex_rt_i == id_rt_i)));

   // A memory wait freezes the pipe, so branch and load-use are re-evaluated afterwards.
   always_comb begin
      pc_write_o    = 1'b1;
      ifid_write_o  = 1'b1;
      ifid_flush_o  = 1'b0;
      idex_flush_o  = 1'b0;
      exmem_flush_o = 1'b0;
      mem_wait_o    = 1'b0;
      br_flush      = 1'b0;
      if (rst_i) begin
         pc_write_o    = 1'b0;
         ifid_write_o  = 1'b0;
         ifid_flush_o  = 1'b1;
         idex_flush_o  = 1'b1;
         exmem_flush_o = 1'b1;
      end else if (mem_wait) begin
         pc_write_o   = 1'b0;
         ifid_write_o = 1'b0;
         mem_wait_o   = 1'b1;
      end else if (mem_branch_taken_i) begin
         ifid_flush_o  = 1'b1;
         idex_flush_o  = 1'b1;
         exmem_flush_o = 1'b1;
         br_flush      = 1'b1;
      end else if (load_use) begin
         pc_write_o   = 1'b0;
         ifid_write_o = 1'b0;
         idex_flush_o = 1'b1;
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (!pc_write_o && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (br_flush && !(&flush_cnt_q))    flush_cnt_d = flush_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= S_RUN;
         rem_q       <= 4'd0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         rem_q       <= rem_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt_o = stall_cnt_q;
   assign flush_cnt_o = flush_cnt_q;

endmodule
